bcd_seq_controller: RTL and testbench
=====================================

Name: bcd_seq_controller

Overview:
- Multi-cycle sequencer for signed add/subtract of two N-digit packed BCD operands.
- Drives one shared single-digit BCD adder, one digit per clock, least significant digit first.
- Subtraction uses the 10's complement of the right operand. A negative result is re-complemented so the output is always magnitude plus a sign flag.
- Sits between the switch/operand capture logic and the HEX display decoders. Uses a start/busy/done handshake.

Parameters:
- DIGITS, 2, number of BCD digits per operand (≥1).
- DW, 4*DIGITS, derived operand/result width. Not overridable.

Ports:
- CLOCK_50  in  1  system clock; all state updates on the rising edge.
- RST  in  1  synchronous, active-high reset.
- start  in  1  request pulse; sampled only in IDLE.
- mode  in  1  0 = add (left+right), 1 = subtract (left−right); captured with start.
- left_bcd  in  DW  left operand, packed BCD; captured with start.
- right_bcd  in  DW  right operand, packed BCD; captured with start.
- busy  out  1  high from the cycle after acceptance until done.
- done  out  1  one-cycle pulse; result flags are valid from this cycle on.
- result_bcd  out  DW  result magnitude, packed BCD.
- carry_out  out  1  add overflow (decimal carry out of the MSD).
- neg  out  1  subtract result negative.
- err  out  1  an operand digit was greater than 9.

Behaviour:
- Reset (synchronous, RST=1 at an edge):
  - State returns to IDLE.
  - All outputs and internal registers clear to 0: result_bcd=0, carry_out=0, neg=0, err=0, busy=0, done=0.
  - Reset mid-operation aborts it; no done is produced.
- States: IDLE, ADD, NEG, DONE.
- IDLE:
  - Accepts start=1: captures mode and operands, clears idx and the flags, goes to ADD.
  - Validity check at capture: if any digit of either operand is greater than 9, set err=1, result_bcd=0, go directly to DONE.
  - In subtract mode, the right operand is stored as its per-digit 9's complement and the digit-0 carry-in is 1. In add mode the carry-in is 0.
- ADD:
  - Each cycle, digit[idx] = bcd_digit_adder(L[idx], R'[idx], carry).
  - The sum is written into result_bcd[idx], the carry is registered, and idx increments.
  - After digit DIGITS−1:
    - Add mode: carry_out = final carry, go to DONE.
    - Subtract mode with final carry=1: result is non-negative, neg=0, go to DONE.
    - Subtract mode with final carry=0: neg=1, clear idx, carry-in=1, go to NEG.
- NEG:
  - Each cycle, result[idx] = bcd_digit_adder(0, 9 − result[idx], carry), in place.
  - After DIGITS cycles, go to DONE.
- DONE:
  - done=1 for exactly one cycle, busy drops to 0, next state is IDLE.
  - result_bcd, carry_out, neg and err hold until the next accepted start.
- busy is high in ADD and NEG only. It is low in IDLE and DONE.
- Latency, counted as edges from the start-sampling edge to done high:
  - Add, or non-negative subtract: DIGITS+1.
  - Negative subtract: 2*DIGITS+1.
  - Error: 1.
- start while busy or in DONE is ignored (not queued).
- start held high re-triggers on the first IDLE cycle after DONE.
- Operand inputs may change freely after capture.
- 0−0 gives result 0, neg=0. A negative zero is impossible because the final carry=1.
- carry_out is always 0 in subtract mode. neg is always 0 in add mode.

Decomposition:
- Package bcd_pkg holds:
  - state enum (IDLE, ADD, NEG, DONE);
  - the constant BCD_MAX = 4'd9;
  - function nines_comp(digit), returning 9 − digit.
- Sub-module bcd_digit_adder: combinational. Inputs a[3:0], b[3:0], cin. Outputs s[3:0], cout. If the binary sum is greater than 9, add 6 and set cout.
- The controller instantiates exactly one bcd_digit_adder, shared by ADD and NEG through operand muxes.

Test Plan (DIGITS=2):
- Add 45+38 (start at edge 0) -> done at edge 3, result 83, carry_out=0, neg=0, err=0; busy high exactly 2 cycles.
- Add 99+01 -> result 00, carry_out=1, done at edge 3.
- Subtract 83−38 -> result 45, neg=0, done at edge 3. Subtract 38−83 -> result 45, neg=1, done at edge 5.
- Operand 0x4A with 0x12 -> err=1, result 00, done at edge 1; next valid start 12+12 -> err cleared, result 24.
- start pulsed again at edge 1 during 45+38 -> ignored; single done at edge 3 with result 83. start held high continuously -> back-to-back runs, each done 4 cycles apart.
- RST asserted at edge 2 of 38−83 -> all outputs 0 at the next cycle, no done pulse; fresh 10−01 then gives 09, neg=0.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared types and helpers for the sequential packed-BCD add/subtract controller.
package bcd_pkg;

  typedef enum logic [1:0] {StIdle, StAdd, StNeg, StDone} stateT;

  localparam logic [3:0] BCD_MAX = 4'd9;

  function automatic logic [3:0] nines_comp(input logic [3:0] digit);
    return BCD_MAX - digit;
  endfunction

endpackage

// File: rtl/bcd_digit_adder.sv
// Single-digit BCD adder: binary sum with +6 decimal correction above 9.
module bcd_digit_adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  logic [4:0] binSum;

  always_comb begin
    binSum = {1'b0, a} + {1'b0, b} + {4'b0, cin};
    s      = binSum[3:0];
    cout   = 1'b0;
    if (binSum > 5'd9) begin
      // Wrapping the low nibble by +6 is the same as (binSum + 6) mod 16.
      s    = binSum[3:0] + 4'd6;
      cout = 1'b1;
    end
  end

endmodule

// File: rtl/bcd_seq_controller.sv
// Digit-serial signed BCD add/subtract sequencer sharing one bcd_digit_adder.
// Results are magnitude plus sign; done is a one-cycle pulse after the DONE state.
module bcd_seq_controller
  import bcd_pkg::*;
#(
  parameter int unsigned DIGITS = 2,
  localparam int unsigned DW = 4 * DIGITS
) (
  input  logic          CLOCK_50,
  input  logic          RST,
  input  logic          start,
  input  logic          mode,
  input  logic [DW-1:0] left_bcd,
  input  logic [DW-1:0] right_bcd,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] result_bcd,
  output logic          carry_out,
  output logic          neg,
  output logic          err
);

  localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(DIGITS - 1);

  stateT           stateQ, stateD;
  logic            modeQ, modeD;
  logic [DW-1:0]   leftQ, leftD;
  logic [DW-1:0]   rightQ, rightD;
  logic [DW-1:0]   resultQ, resultD;
  logic [IdxW-1:0] idxQ, idxD;
  logic            carryQ, carryD;
  logic            carryOutQ, carryOutD;
  logic            negQ, negD;
  logic            errQ, errD;
  logic            doneQ, doneD;

  logic [3:0]      curLeft, curRight, curResult;
  logic [3:0]      adA, adB, adSum;
  logic            adCout;
  logic [DW-1:0]   rightComp;
  logic            badOperand;

  bcd_digit_adder u_adder (
    .a    (adA),
    .b    (adB),
    .cin  (carryQ),
    .s    (adSum),
    .cout (adCout)
  );

  // Digit select for the current index, plus capture-time operand checks.
  always_comb begin
    curLeft    = 4'd0;
    curRight   = 4'd0;
    curResult  = 4'd0;
    rightComp  = '0;
    badOperand = 1'b0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (idxQ == IdxW'(i)) begin
        curLeft   = leftQ[4*i +: 4];
        curRight  = rightQ[4*i +: 4];
        curResult = resultQ[4*i +: 4];
      end
      rightComp[4*i +: 4] = nines_comp(right_bcd[4*i +: 4]);
      if (left_bcd[4*i +: 4] > BCD_MAX || right_bcd[4*i +: 4] > BCD_MAX) begin
        badOperand = 1'b1;
      end
    end
    adA = (stateQ == StNeg) ? 4'd0 : curLeft;
    adB = (stateQ == StNeg) ? nines_comp(curResult) : curRight;
  end

  always_comb begin
    stateD    = stateQ;
    modeD     = modeQ;
    leftD     = leftQ;
    rightD    = rightQ;
    resultD   = resultQ;
    idxD      = idxQ;
    carryD    = carryQ;
    carryOutD = carryOutQ;
    negD      = negQ;
    errD      = errQ;
    doneD     = 1'b0;

    unique case (stateQ)
      StIdle: begin
        if (start) begin
          modeD     = mode;
          leftD     = left_bcd;
          rightD    = mode ? rightComp : right_bcd;
          idxD      = '0;
          carryD    = mode;
          carryOutD = 1'b0;
          negD      = 1'b0;
          errD      = badOperand;
          resultD   = '0;
          stateD    = badOperand ? StDone : StAdd;
        end
      end
      StAdd, StNeg: begin
        for (int i = 0; i < int'(DIGITS); i++) begin
          if (idxQ == IdxW'(i)) resultD[4*i +: 4] = adSum;
        end
        carryD = adCout;
        idxD   = idxQ + 1'b1;
        if (idxQ == LastIdx) begin
          stateD = StDone;
          if (stateQ == StAdd) begin
            if (!modeQ) begin
              carryOutD = adCout;
            end else if (!adCout) begin
              // No final carry in subtract: result is the 10's complement, undo it.
              negD   = 1'b1;
              idxD   = '0;
              carryD = 1'b1;
              stateD = StNeg;
            end
          end
        end
      end
      StDone: begin
        doneD  = 1'b1;
        stateD = StIdle;
      end
      default: stateD = StIdle;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (RST) begin
      stateQ    <= StIdle;
      modeQ     <= 1'b0;
      leftQ     <= '0;
      rightQ    <= '0;
      resultQ   <= '0;
      idxQ      <= '0;
      carryQ    <= 1'b0;
      carryOutQ <= 1'b0;
      negQ      <= 1'b0;
      errQ      <= 1'b0;
      doneQ     <= 1'b0;
    end else begin
      stateQ    <= stateD;
      modeQ     <= modeD;
      leftQ     <= leftD;
      rightQ    <= rightD;
      resultQ   <= resultD;
      idxQ      <= idxD;
      carryQ    <= carryD;
      carryOutQ <= carryOutD;
      negQ      <= negD;
      errQ      <= errD;
      doneQ     <= doneD;
    end
  end

  assign busy       = (stateQ == StAdd) || (stateQ == StNeg);
  assign done       = doneQ;
  assign result_bcd = resultQ;
  assign carry_out  = carryOutQ;
  assign neg        = negQ;
  assign err        = errQ;

endmodule

// File: tb/tb_bcd_seq_controller.sv
// Directed bench for bcd_seq_controller (DIGITS=2) with a queue-based scoreboard
// fed by an integer reference model.
module tb_bcd_seq_controller;

  logic       clk;
  logic       rst;
  logic       start;
  logic       mode;
  logic [7:0] leftBcd;
  logic [7:0] rightBcd;
  logic       busy;
  logic       done;
  logic [7:0] resultBcd;
  logic       carryOut;
  logic       neg;
  logic       err;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int startCyc = 0;

  typedef struct {
    string      tag;
    logic [7:0] res;
    logic       co;
    logic       ng;
    logic       er;
    int         lat;
  } expT;

  expT sb[$];

  bcd_seq_controller #(.DIGITS(2)) dut (
    .CLOCK_50   (clk),
    .RST        (rst),
    .start      (start),
    .mode       (mode),
    .left_bcd   (leftBcd),
    .right_bcd  (rightBcd),
    .busy       (busy),
    .done       (done),
    .result_bcd (resultBcd),
    .carry_out  (carryOut),
    .neg        (neg),
    .err        (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic expT model(input string tag, input logic m, input logic [7:0] l,
                                input logic [7:0] r);
    expT e;
    int a, b, d;
    e.tag = tag;
    e.res = 8'h00;
    e.co  = 1'b0;
    e.ng  = 1'b0;
    e.er  = 1'b0;
    e.lat = 3;
    if (l[7:4] > 9 || l[3:0] > 9 || r[7:4] > 9 || r[3:0] > 9) begin
      e.er  = 1'b1;
      e.lat = 1;
      return e;
    end
    a = int'(l[7:4]) * 10 + int'(l[3:0]);
    b = int'(r[7:4]) * 10 + int'(r[3:0]);
    if (!m) begin
      d    = a + b;
      e.co = (d >= 100);
      d    = d % 100;
    end else begin
      d = a - b;
      if (d < 0) begin
        e.ng  = 1'b1;
        d     = -d;
        e.lat = 5;
      end
    end
    e.res[7:4] = 4'(d / 10);
    e.res[3:0] = 4'(d % 10);
    return e;
  endfunction

  // Waits (bounded) for done; latency is edges since the start-sampling edge.
  task automatic waitDone(output int lat, output int busyCnt, output bit seen);
    seen    = 1'b0;
    busyCnt = 0;
    lat     = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        lat  = cyc - startCyc;
      end else if (busy) begin
        busyCnt++;
      end
    end
  endtask

  task automatic countDones(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (done) cnt++;
    end
  endtask

  task automatic runOp(input string tag, input logic m, input logic [7:0] l,
                       input logic [7:0] r, output int busyCnt);
    expT e;
    int  lat;
    bit  seen;
    sb.push_back(model(tag, m, l, r));
    @(negedge clk);
    mode     = m;
    leftBcd  = l;
    rightBcd = r;
    start    = 1'b1;
    @(posedge clk);
    #1;
    startCyc = cyc;
    start    = 1'b0;
    leftBcd  = 8'h77;
    rightBcd = 8'h55;
    waitDone(lat, busyCnt, seen);
    e = sb.pop_front();
    check({e.tag, " done"}, 32'(seen), 32'd1);
    check({e.tag, " latency"}, 32'(lat), 32'(e.lat));
    check({e.tag, " result"}, 32'(resultBcd), 32'(e.res));
    check({e.tag, " carry"}, 32'(carryOut), 32'(e.co));
    check({e.tag, " neg"}, 32'(neg), 32'(e.ng));
    check({e.tag, " err"}, 32'(err), 32'(e.er));
    @(negedge clk);
    check({e.tag, " done pulse width"}, 32'(done), 32'd0);
  endtask

  initial begin
    int  bc, lat, cnt, t1;
    bit  seen;
    logic       rm;
    logic [7:0] rl, rr;

    rst      = 1'b1;
    start    = 1'b0;
    mode     = 1'b0;
    leftBcd  = 8'h00;
    rightBcd = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset result", 32'(resultBcd), 32'd0);
    check("reset carry", 32'(carryOut), 32'd0);
    check("reset neg", 32'(neg), 32'd0);
    check("reset err", 32'(err), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    rst = 1'b0;

    runOp("add 45+38", 1'b0, 8'h45, 8'h38, bc);
    check("add 45+38 busy cycles", 32'(bc), 32'd2);
    runOp("add 99+01", 1'b0, 8'h99, 8'h01, bc);
    runOp("sub 83-38", 1'b1, 8'h83, 8'h38, bc);
    runOp("sub 38-83", 1'b1, 8'h38, 8'h83, bc);
    check("sub 38-83 busy cycles", 32'(bc), 32'd4);
    runOp("err 4A+12", 1'b0, 8'h4A, 8'h12, bc);
    runOp("add 12+12", 1'b0, 8'h12, 8'h12, bc);
    runOp("sub 00-00", 1'b1, 8'h00, 8'h00, bc);
    runOp("sub 10-01", 1'b1, 8'h10, 8'h01, bc);

    for (int k = 0; k < 6; k++) begin
      rm = 1'($urandom_range(0, 1));
      rl = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      rr = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      runOp($sformatf("rand%0d %0s %h,%h", k, rm ? "sub" : "add", rl, rr), rm, rl, rr, bc);
    end

    // Extra start pulse while busy must be ignored.
    @(negedge clk);
    mode = 1'b0; leftBcd = 8'h45; rightBcd = 8'h38; start = 1'b1;
    @(posedge clk);
    #1;
    startCyc = cyc;
    start    = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    waitDone(lat, bc, seen);
    check("ignored start done", 32'(seen), 32'd1);
    check("ignored start latency", 32'(lat), 32'd3);
    check("ignored start result", 32'(resultBcd), 32'h83);
    countDones(8, cnt);
    check("ignored start extra dones", 32'(cnt), 32'd0);

    // Held start re-triggers back to back, dones 4 cycles apart.
    @(negedge clk);
    mode = 1'b1; leftBcd = 8'h83; rightBcd = 8'h38; start = 1'b1;
    @(posedge clk);
    #1;
    startCyc = cyc;
    waitDone(lat, bc, seen);
    check("held first latency", 32'(lat), 32'd3);
    check("held first result", 32'(resultBcd), 32'h45);
    t1       = cyc;
    startCyc = t1;
    waitDone(lat, bc, seen);
    start = 1'b0;
    check("held second done", 32'(seen), 32'd1);
    check("held done spacing", 32'(lat), 32'd4);
    check("held second result", 32'(resultBcd), 32'h45);
    countDones(8, cnt);
    check("held stop extra dones", 32'(cnt), 32'd0);

    // Reset at edge 2 of a negative subtract aborts it.
    @(negedge clk);
    mode = 1'b1; leftBcd = 8'h38; rightBcd = 8'h83; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort result", 32'(resultBcd), 32'd0);
    check("abort neg", 32'(neg), 32'd0);
    check("abort busy", 32'(busy), 32'd0);
    check("abort done", 32'(done), 32'd0);
    rst = 1'b0;
    countDones(8, cnt);
    check("abort no done", 32'(cnt), 32'd0);
    runOp("post-abort sub 10-01", 1'b1, 8'h10, 8'h01, bc);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
